// File: rtl/bias_buffer_pkg.sv
`default_nettype none
// bias_buffer_pkg: state encodings, default widths and status bit positions
// shared by the bias replay buffer and its RAM.
package bias_buffer_pkg;

  localparam int DATA_W_DEF = 128;
  localparam int DEPTH_DEF  = 256;
  localparam int ADDR_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;

  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_STATE_MSB = 1;
  localparam int STAT_LOADED    = 2;
  localparam int STAT_CFG_ERR   = 3;

endpackage
`default_nettype wire

// File: rtl/bias_buffer_ram.sv
`default_nettype none
// bias_buffer_ram: simple dual-port RAM, one write port and one registered
// read port; the read register holds its value while rd_en is low.
module bias_buffer_ram #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/bias_buffer.sv
`default_nettype none
// bias_buffer: captures one layer of bias words and replays them cfg_repeat
// times as a tlast-framed stream. BIAS_BUF_CFG_CHECK_EN flags oversize configs.
module bias_buffer
  import bias_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W:0]   cfg_words,
  input  logic [15:0]       cfg_repeat,
  input  logic              s_axis_bias_tvalid,
  output logic              s_axis_bias_tready,
  input  logic [DATA_W-1:0] s_axis_bias_tdata,
  output logic              m_axis_bias_tvalid,
  input  logic              m_axis_bias_tready,
  output logic [DATA_W-1:0] m_axis_bias_tdata,
  output logic              m_axis_bias_tlast,
  output logic [3:0]        status_bb
);

  typedef logic [ADDR_W:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE = cnt_t'(1);

  state_t            state, state_nx;
  cnt_t              words_q, wr_cnt, rd_addr, words_in;
  logic [15:0]       repeat_q, rd_pass, pass_cnt;
  logic              mem_loaded, cfg_err, oversize;
  logic              rd_done, p_valid, p_last;
  logic              cfg_fire, s_fire, m_fire, out_adv, p_adv, rd_issue;
  logic              load_last, serve_last, rd_wrap;
  logic [DATA_W-1:0] ram_q;

  always_comb begin
    oversize   = cfg_words > DEPTH_C;
    words_in   = oversize ? DEPTH_C : cfg_words;
    cfg_fire   = cfg_valid && cfg_ready;
    s_fire     = s_axis_bias_tvalid && s_axis_bias_tready;
    m_fire     = m_axis_bias_tvalid && m_axis_bias_tready;
    load_last  = (wr_cnt + CNT_ONE) == words_q;
    serve_last = m_fire && m_axis_bias_tlast && (pass_cnt == repeat_q - 16'd1);
    // Two-stage read pipe: RAM output register (p_*) feeding the output register.
    out_adv    = !m_axis_bias_tvalid || m_axis_bias_tready;
    p_adv      = !p_valid || out_adv;
    rd_issue   = (state == ST_SERVE) && p_adv && !rd_done;
    rd_wrap    = rd_addr == (words_q - CNT_ONE);

    state_nx = state;
    case (state)
      ST_IDLE:  if (cfg_fire && words_in != '0) state_nx = ST_LOAD;
      ST_LOAD:  if (s_fire && load_last)        state_nx = ST_SERVE;
      ST_SERVE: if (serve_last)                 state_nx = ST_IDLE;
      default:                                  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready          <= 1'b0;
      s_axis_bias_tready <= 1'b0;
      m_axis_bias_tvalid <= 1'b0;
      m_axis_bias_tdata  <= '0;
      m_axis_bias_tlast  <= 1'b0;
      words_q            <= '0;
      repeat_q           <= '0;
      wr_cnt             <= '0;
      rd_addr            <= '0;
      rd_pass            <= '0;
      rd_done            <= 1'b0;
      pass_cnt           <= '0;
      p_valid            <= 1'b0;
      p_last             <= 1'b0;
      mem_loaded         <= 1'b0;
    end else begin
      cfg_ready          <= (state_nx == ST_IDLE);
      s_axis_bias_tready <= (state_nx == ST_LOAD);
      case (state)
        ST_IDLE: begin
          if (cfg_fire) begin
            words_q    <= words_in;
            repeat_q   <= (cfg_repeat == 16'd0) ? 16'd1 : cfg_repeat;
            mem_loaded <= 1'b0;
            wr_cnt     <= '0;
            rd_addr    <= '0;
            rd_pass    <= '0;
            rd_done    <= 1'b0;
            pass_cnt   <= '0;
            p_valid    <= 1'b0;
            p_last     <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (s_fire) begin
            wr_cnt <= wr_cnt + CNT_ONE;
            if (load_last) mem_loaded <= 1'b1;
          end
        end
        ST_SERVE: begin
          if (rd_issue) begin
            p_last <= rd_wrap;
            if (rd_wrap) begin
              rd_addr <= '0;
              if (rd_pass == repeat_q - 16'd1) rd_done <= 1'b1;
              else                             rd_pass <= rd_pass + 16'd1;
            end else begin
              rd_addr <= rd_addr + CNT_ONE;
            end
          end
          if (p_adv) p_valid <= rd_issue;
          if (out_adv) begin
            m_axis_bias_tvalid <= p_valid;
            m_axis_bias_tdata  <= ram_q;
            m_axis_bias_tlast  <= p_valid && p_last;
          end
          if (m_fire && m_axis_bias_tlast) pass_cnt <= pass_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef BIAS_BUF_CFG_CHECK_EN
  // Sticky until reset so software can see any clamped layer after the fact.
  always_ff @(posedge clk) begin
    if (!rst_n)                    cfg_err <= 1'b0;
    else if (cfg_fire && oversize) cfg_err <= 1'b1;
  end
`else
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    status_bb                                = '0;
    status_bb[STAT_STATE_MSB:STAT_STATE_LSB] = state;
    status_bb[STAT_LOADED]                   = mem_loaded;
    status_bb[STAT_CFG_ERR]                  = cfg_err;
  end

  bias_buffer_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (s_fire),
    .wr_addr (wr_cnt[ADDR_W-1:0]),
    .wr_data (s_axis_bias_tdata),
    .rd_en   (rd_issue),
    .rd_addr (rd_addr[ADDR_W-1:0]),
    .rd_data (ram_q)
  );

endmodule
`default_nettype wire
